aes_encryption_seq: RTL and testbench

AES_ENCRYPTION_SEQ -- requirements
Module: aes_encryption_seq

---
 rtl/aes_encryption_seq.sv | 179 +++++++++++++++++
 tb/tb_aes_encryption_seq.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/aes_encryption_seq.sv
// AES-128 forward cipher, one round per clock, with a valid/ready handshake on each side.
// The round key is expanded on the fly alongside the state.
module aes_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y_o = SBOX[a_i];
endmodule

module aes_encryption_seq #(
  parameter int N  = 128,
  parameter int Nr = 10,
  parameter int Nk = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  input  logic [N-1:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t         fsm_q;
  logic [3:0]     rnd_q;
  logic [127:0]   state_q, state_d;
  logic [N-1:0]   rk_q, rk_d;
  logic [127:0]   out_q;
  logic           out_valid_q, busy_q, in_ready_q;

  logic [7:0]     sb [16];
  logic [7:0]     sr [16];
  logic [127:0]   shr, mc;
  logic [31:0]    w [4];
  logic [31:0]    nw [4];
  logic [31:0]    rot, subw, temp;
  logic [7:0]     rcon;
  logic           last;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  for (genvar i = 0; i < 16; i++) begin : g_sub
    aes_sbox u_sb (.a_i(state_q[127-8*i -: 8]), .y_o(sb[i]));
  end

  // State byte i sits at row i%4, column i/4; ShiftRows rotates row r left by r.
  always_comb begin
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
  end

  always_comb begin
    shr = '0;
    mc  = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      shr[127-32*c -: 32] = {sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]};
      mc[127-32*c -: 32] = {
        xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3],
        sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3],
        sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3],
        xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3])
      };
    end
  end

  always_comb begin
    case (rnd_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_kw
    assign w[i] = rk_q[N-1-32*i -: 32];
    aes_sbox u_ks (.a_i(rot[31-8*i -: 8]), .y_o(subw[31-8*i -: 8]));
  end

  assign rot  = {w[3][23:0], w[3][31:24]};
  assign temp = subw ^ {rcon, 24'h000000};

  always_comb begin
    nw[0] = w[0] ^ temp;
    for (int unsigned i = 1; i < 4; i++) begin
      nw[i] = (i < Nk) ? (w[i] ^ nw[i-1]) : '0;
    end
  end

  assign rk_d    = {nw[0], nw[1], nw[2], nw[3]};
  assign last    = (rnd_q == 4'(Nr));
  assign state_d = (last ? shr : mc) ^ rk_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      rnd_q       <= '0;
      state_q     <= '0;
      rk_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            state_q    <= in ^ key;
            rk_q       <= key;
            rnd_q      <= 4'd1;
            fsm_q      <= ROUND;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
          end
        end
        ROUND: begin
          state_q <= state_d;
          rk_q    <= rk_d;
          if (last) begin
            fsm_q       <= DONE;
            out_q       <= state_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            rnd_q <= rnd_q + 4'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;
endmodule

// File: tb/tb_aes_encryption_seq.sv
// Directed bench for aes_encryption_seq: known-answer vectors, latency, back-pressure and reset abort.
module tb_aes_encryption_seq;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_blk = '0;
  logic [127:0] key = '0;
  logic         in_ready, out_valid, busy;
  logic [127:0] out_blk;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes_encryption_seq #(.N(128), .Nr(10), .Nk(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_blk),
    .key       (key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_blk),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accepts one block, waits (bounded) for out_valid and leaves the DUT in DONE.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp, input bit scramble);
    int unsigned lat;
    in_blk   = pt;
    key      = k;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check({tag, " busy after accept"}, 128'(busy), 128'(1'b1));
    check({tag, " in_ready after accept"}, 128'(in_ready), 128'(1'b0));
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        in_blk   = {$urandom, $urandom, $urandom, $urandom};
        key      = {$urandom, $urandom, $urandom, $urandom};
        in_valid = 1'($urandom_range(0, 1));
      end
      step();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, " latency"}, 128'(lat), 128'(10));
    check({tag, " ciphertext"}, out_blk, exp);
    check({tag, " in_ready in DONE"}, 128'(in_ready), 128'(1'b0));
    check({tag, " busy in DONE"}, 128'(busy), 128'(1'b0));
  endtask

  task automatic handshake(input string tag, input logic [127:0] exp);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, 128'(out_valid), 128'(1'b0));
    check({tag, " in_ready after handshake"}, 128'(in_ready), 128'(1'b1));
    check({tag, " out held after handshake"}, out_blk, exp);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned spur;

    #12;
    check("reset in_ready", 128'(in_ready), 128'(1'b1));
    check("reset out_valid", 128'(out_valid), 128'(1'b0));
    check("reset busy", 128'(busy), 128'(1'b0));
    check("reset out", out_blk, '0);
    #10 rst_n = 1'b1;
    step();

    repeat (3) step();
    check("idle hold busy", 128'(busy), 128'(1'b0));
    check("idle hold in_ready", 128'(in_ready), 128'(1'b1));

    run_block("C1", C1_PT, C1_KEY, C1_CT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      out_ready = 1'b0;
      step();
      check("bp out stable", out_blk, C1_CT);
      check("bp out_valid", 128'(out_valid), 128'(1'b1));
      check("bp in_ready", 128'(in_ready), 128'(1'b0));
    end
    handshake("C1", C1_CT);

    run_block("AppB", B_PT, B_KEY, B_CT, 1'b0);
    handshake("AppB", B_CT);

    run_block("Zero", '0, '0, Z_CT, 1'b0);
    handshake("Zero", Z_CT);

    run_block("C1 scrambled", C1_PT, C1_KEY, C1_CT, 1'b1);
    handshake("C1 scrambled", C1_CT);

    in_blk   = B_PT;
    key      = B_KEY;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("abort out cleared", out_blk, '0);
    check("abort out_valid", 128'(out_valid), 128'(1'b0));
    check("abort busy", 128'(busy), 128'(1'b0));
    check("abort in_ready", 128'(in_ready), 128'(1'b1));
    step();
    step();
    #2 rst_n = 1'b1;
    spur = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (out_valid) spur++;
    end
    check("abort no spurious out_valid", 128'(spur), 128'(0));
    run_block("C1 after abort", C1_PT, C1_KEY, C1_CT, 1'b0);
    handshake("C1 after abort", C1_CT);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
